// File: rtl/ibex_icache_fill_ctrl.sv
// Instruction-cache line-fill controller.
// Takes one miss at a time, fetches the line's beats over the req/gnt/rvalid bus,
// buffers them, and issues a single tag/data RAM write into the victim way.
// Bus errors suppress the RAM write; aborts drain outstanding beats silently.
// Optional: define IBEX_ICACHE_FILL_CWF_EN for critical-word-first beat ordering.
module ibex_icache_fill_ctrl #(
    parameter int unsigned AddrW     = 32,
    parameter int unsigned BusW      = 32,
    parameter int unsigned LineBeats = 2,
    parameter int unsigned LineW     = 3,
    parameter int unsigned IndexW    = 8,
    parameter int unsigned NumWays   = 2,
    parameter int unsigned TagW      = AddrW - IndexW - LineW + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      miss_req_i,
    input  logic [AddrW-1:0]          miss_addr_i,
    input  logic [NumWays-1:0]        miss_way_i,
    output logic                      miss_gnt_o,
    input  logic                      abort_i,
    output logic                      instr_req_o,
    output logic [AddrW-1:0]          instr_addr_o,
    input  logic                      instr_gnt_i,
    input  logic                      instr_rvalid_i,
    input  logic [BusW-1:0]           instr_rdata_i,
    input  logic                      instr_err_i,
    output logic                      fill_we_o,
    output logic [IndexW-1:0]         fill_index_o,
    output logic [NumWays-1:0]        fill_way_o,
    output logic [TagW-1:0]           fill_tag_o,
    output logic [LineBeats*BusW-1:0] fill_data_o,
    output logic                      fill_done_o,
    output logic                      fill_err_o,
    output logic                      busy_o
);

    localparam int unsigned CntW  = $clog2(LineBeats) + 1;
    localparam int unsigned BeatW = $clog2(LineBeats);
    localparam int unsigned ByteW = $clog2(BusW / 8);
    localparam logic [CntW-1:0] LastBeat = CntW'(LineBeats - 1);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StWrite, StDrain} state_e;

    state_e                         state_q, state_d;
    logic [CntW-1:0]                req_cnt_q, req_cnt_d;
    logic [CntW-1:0]                rsp_cnt_q, rsp_cnt_d;
    logic                           err_q, err_d;
    logic                           abort_pend_q, abort_pend_d;
    logic [AddrW-1:0]               base_q, base_d;
    logic [IndexW-1:0]              index_q, index_d;
    logic [NumWays-1:0]             way_q, way_d;
    logic [TagW-1:0]                tag_q, tag_d;
    logic [LineBeats-1:0][BusW-1:0] line_q, line_d;
    logic [BeatW-1:0]               req_slot, rsp_slot;
    logic                           unused_addr_bits;

    // Offset bits only steer beat order; the line base drops them.
    assign unused_addr_bits = ^miss_addr_i[LineW-1:0];

`ifdef IBEX_ICACHE_FILL_CWF_EN
    logic [BeatW-1:0] start_q, start_d;

    // Beat slots rotate from the critical word and wrap within the line.
    assign req_slot = req_cnt_q[BeatW-1:0] + start_q;
    assign rsp_slot = rsp_cnt_q[BeatW-1:0] + start_q;

    // Critical-word start beat register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) start_q <= '0;
        else       start_q <= start_d;
    end

    // Start beat captured on acceptance only.
    always_comb begin
        start_d = start_q;
        if (state_q == StIdle && miss_gnt_o) start_d = miss_addr_i[LineW-1:ByteW];
    end
`else
    assign req_slot = req_cnt_q[BeatW-1:0];
    assign rsp_slot = rsp_cnt_q[BeatW-1:0];
`endif

    // Fill state and line buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            base_q       <= '0;
            index_q      <= '0;
            way_q        <= '0;
            tag_q        <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            rsp_cnt_q    <= rsp_cnt_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            base_q       <= base_d;
            index_q      <= index_d;
            way_q        <= way_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
        end
    end

    // Next-state logic, response capture and outputs.
    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        base_d       = base_q;
        index_d      = index_q;
        way_d        = way_q;
        tag_d        = tag_q;
        line_d       = line_q;
        miss_gnt_o   = 1'b0;
        instr_req_o  = 1'b0;
        instr_addr_o = '0;
        fill_we_o    = 1'b0;
        fill_index_o = '0;
        fill_way_o   = '0;
        fill_tag_o   = '0;
        fill_data_o  = '0;
        fill_done_o  = 1'b0;
        fill_err_o   = 1'b0;
        busy_o       = (state_q != StIdle);

        // Responses may land while still requesting, waiting or draining.
        if (instr_rvalid_i && (state_q inside {StReq, StWait, StDrain})) begin
            line_d[rsp_slot] = instr_rdata_i;
            err_d            = err_q | instr_err_i;
            rsp_cnt_d        = rsp_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                miss_gnt_o = miss_req_i & ~abort_i;
                if (miss_gnt_o) begin
                    base_d       = {miss_addr_i[AddrW-1:LineW], LineW'(0)};
                    index_d      = miss_addr_i[IndexW+LineW-1:LineW];
                    way_d        = miss_way_i;
                    tag_d        = {1'b1, miss_addr_i[AddrW-1:IndexW+LineW]};
                    req_cnt_d    = '0;
                    rsp_cnt_d    = '0;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = StReq;
                end
            end
            StReq: begin
                instr_req_o  = 1'b1;
                instr_addr_o = base_q + (AddrW'(req_slot) << ByteW);
                // An ungranted request must stay up; remember the abort until gnt.
                if (abort_i) abort_pend_d = 1'b1;
                if (instr_gnt_i) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                    if (abort_i || abort_pend_q)  state_d = StDrain;
                    else if (req_cnt_q == LastBeat) state_d = StWait;
                end
            end
            StWait: begin
                if (abort_i) state_d = StDrain;
                else if (instr_rvalid_i && rsp_cnt_q == LastBeat) state_d = StWrite;
            end
            StWrite: begin
                fill_done_o  = 1'b1;
                fill_err_o   = err_q;
                fill_we_o    = ~err_q;
                fill_index_o = index_q;
                fill_way_o   = way_q;
                fill_tag_o   = tag_q;
                fill_data_o  = line_q;
                state_d      = StIdle;
            end
            StDrain: begin
                if (rsp_cnt_d == req_cnt_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ibex_icache_fill_ctrl.sv
// Directed testbench for ibex_icache_fill_ctrl (default parameters).
// Bus responder grants combinationally unless held and returns data = addr ^ 0xA5A5_0000.
module tb_ibex_icache_fill_ctrl;

    localparam logic [31:0] DataKey = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = '0;
    logic [1:0]  miss_way = '0;
    logic        miss_gnt;
    logic        abort = 1'b0;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid = 1'b0;
    logic [31:0] instr_rdata = '0;
    logic        instr_err = 1'b0;
    logic        fill_we;
    logic [7:0]  fill_index;
    logic [1:0]  fill_way;
    logic [21:0] fill_tag;
    logic [63:0] fill_data;
    logic        fill_done;
    logic        fill_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic hold_gnt = 1'b0;
    int err_beat = -1;
    int beat = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    logic [31:0] req_log[$];

    logic [63:0] c_data;
    logic [7:0]  c_index;
    logic [1:0]  c_way;
    logic [21:0] c_tag;
    logic        c_we, c_err, found;
    int          lat, t0;

    always #5 clk = ~clk;

    ibex_icache_fill_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .miss_req_i     (miss_req),
        .miss_addr_i    (miss_addr),
        .miss_way_i     (miss_way),
        .miss_gnt_o     (miss_gnt),
        .abort_i        (abort),
        .instr_req_o    (instr_req),
        .instr_addr_o   (instr_addr),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .instr_rdata_i  (instr_rdata),
        .instr_err_i    (instr_err),
        .fill_we_o      (fill_we),
        .fill_index_o   (fill_index),
        .fill_way_o     (fill_way),
        .fill_tag_o     (fill_tag),
        .fill_data_o    (fill_data),
        .fill_done_o    (fill_done),
        .fill_err_o     (fill_err),
        .busy_o         (busy)
    );

    assign instr_gnt = instr_req & ~hold_gnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder (one-cycle rvalid) plus request/event logging.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_rvalid <= 1'b0;
            instr_rdata  <= '0;
            instr_err    <= 1'b0;
            beat         <= 0;
        end else begin
            instr_rvalid <= instr_req & instr_gnt;
            instr_rdata  <= instr_addr ^ DataKey;
            instr_err    <= instr_req & instr_gnt & (beat == err_beat);
            if (miss_gnt) beat <= 0;
            else if (instr_req & instr_gnt) beat <= beat + 1;
            if (instr_req & instr_gnt) req_log.push_back(instr_addr);
            if (fill_done) done_cnt <= done_cnt + 1;
            if (fill_we) we_cnt <= we_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] line_of(input logic [31:0] base);
        return {(base + 32'd4) ^ DataKey, base ^ DataKey};
    endfunction

    // Caller sits just after a negedge; returns at the negedge of the cycle after acceptance.
    task automatic start_miss(input logic [31:0] a, input logic [1:0] w);
        miss_req  = 1'b1;
        miss_addr = a;
        miss_way  = w;
        #1;
        checks++;
        if (miss_gnt !== 1'b1) begin
            errors++;
            $display("FAIL miss_gnt_accept: got %b want 1", miss_gnt);
        end
        t0 = cyc;
        @(negedge clk);
        miss_req = 1'b0;
    endtask

    // Returns at the negedge of the WRITE cycle, with its outputs captured.
    task automatic wait_done();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (fill_done === 1'b1) begin
                found   = 1'b1;
                c_data  = fill_data;
                c_index = fill_index;
                c_way   = fill_way;
                c_tag   = fill_tag;
                c_we    = fill_we;
                c_err   = fill_err;
                lat     = cyc - t0;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL fill_done_timeout: got no fill_done want fill_done within 40 cycles");
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        miss_req = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (instr_req !== 1'b0 || instr_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b addr=%h want 0/0", instr_req, instr_addr);
        end
        checks++;
        if (fill_we !== 1'b0 || fill_done !== 1'b0 || fill_err !== 1'b0 || fill_data !== 64'h0
            || fill_tag !== 22'h0 || fill_index !== 8'h0 || fill_way !== 2'b00) begin
            errors++;
            $display("FAIL reset_fill: got we=%b done=%b err=%b data=%h want all 0",
                     fill_we, fill_done, fill_err, fill_data);
        end
        checks++;
        if (miss_gnt !== 1'b1) begin errors++; $display("FAIL reset_miss_gnt: got %b want 1", miss_gnt); end
        abort = 1'b1;
        #1;
        checks++;
        if (miss_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_miss_gnt_abort: got %b want 0", miss_gnt);
        end
        miss_req = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n0;
        logic [31:0] exp0, exp1, got0, got1;
`ifdef IBEX_ICACHE_FILL_CWF_EN
        exp0 = 32'h1234; exp1 = 32'h1230;
`else
        exp0 = 32'h1230; exp1 = 32'h1234;
`endif
        n0 = req_log.size();
        start_miss(32'h0000_1234, 2'b10);
        wait_done();
        checks++;
        if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++;
        if (req_log.size() - n0 != 2) begin
            errors++;
            $display("FAIL basic_req_count: got %0d want 2", req_log.size() - n0);
        end
        got0 = (req_log.size() > n0) ? req_log[n0] : 32'hxxxx_xxxx;
        got1 = (req_log.size() > n0 + 1) ? req_log[n0+1] : 32'hxxxx_xxxx;
        checks++;
        if (got0 !== exp0 || got1 !== exp1) begin
            errors++;
            $display("FAIL basic_req_order: got %h,%h want %h,%h", got0, got1, exp0, exp1);
        end
        checks++;
        if (c_index !== 8'h46) begin errors++; $display("FAIL basic_index: got %h want 46", c_index); end
        // 0x1234 >> 11 = 2, valid bit on top.
        checks++;
        if (c_tag !== 22'h200002) begin errors++; $display("FAIL basic_tag: got %h want 200002", c_tag); end
        checks++;
        if (c_way !== 2'b10) begin errors++; $display("FAIL basic_way: got %b want 10", c_way); end
        checks++;
        if (c_data !== 64'hA5A51234_A5A51230) begin
            errors++;
            $display("FAIL basic_data: got %h want a5a51234a5a51230", c_data);
        end
        checks++;
        if (c_we !== 1'b1 || c_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_we_err: got we=%b err=%b want 1/0", c_we, c_err);
        end
`ifdef IBEX_ICACHE_FILL_CWF_EN
        // First response came from 0x1234 and belongs in slot 1.
        checks++;
        if (c_data[63:32] !== (exp0 ^ DataKey)) begin
            errors++;
            $display("FAIL cwf_slot1: got %h want %h", c_data[63:32], exp0 ^ DataKey);
        end
`endif
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fill_we !== 1'b0 || fill_data !== 64'h0) begin
            errors++;
            $display("FAIL basic_after: got busy=%b we=%b data=%h want 0/0/0", busy, fill_we, fill_data);
        end
    endtask

    task automatic test_gnt_stall();
        hold_gnt = 1'b1;
        start_miss(32'h0000_1230, 2'b01);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (instr_req !== 1'b1 || instr_addr !== 32'h1230) begin
                errors++;
                $display("FAIL stall_hold%0d: got req=%b addr=%h want 1/00001230", i, instr_req, instr_addr);
            end
            @(negedge clk);
        end
        hold_gnt = 1'b0;
        wait_done();
        checks++;
        if (lat != 7) begin errors++; $display("FAIL stall_latency: got %0d want 7", lat); end
        checks++;
        if (c_data !== line_of(32'h1230) || c_we !== 1'b1 || c_way !== 2'b01) begin
            errors++;
            $display("FAIL stall_fill: got data=%h we=%b way=%b want %h/1/01",
                     c_data, c_we, c_way, line_of(32'h1230));
        end
        @(negedge clk);
    endtask

    task automatic test_bus_error();
        int w0;
        w0 = we_cnt;
        err_beat = 1;
        start_miss(32'h0000_2008, 2'b01);
        wait_done();
        checks++;
        if (c_err !== 1'b1 || c_we !== 1'b0) begin
            errors++;
            $display("FAIL err_flags: got err=%b we=%b want 1/0", c_err, c_we);
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL err_latency: got %0d want 4", lat); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || we_cnt != w0) begin
            errors++;
            $display("FAIL err_after: got busy=%b writes=%0d want 0/%0d", busy, we_cnt, w0);
        end
        err_beat = -1;
    endtask

    task automatic test_abort();
        int n0, d0, w0;
        bit idle;
        n0 = req_log.size();
        d0 = done_cnt;
        w0 = we_cnt;
        hold_gnt = 1'b1;
        start_miss(32'h0000_3000, 2'b10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (instr_req !== 1'b1 || instr_addr !== 32'h3000) begin
            errors++;
            $display("FAIL abort_hold: got req=%b addr=%h want 1/00003000", instr_req, instr_addr);
        end
        hold_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_drain: got req=%b busy=%b want 0/1", instr_req, busy);
        end
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge clk);
            idle = (busy === 1'b0);
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL abort_idle: got busy=1 want 0 within 10 cycles"); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_log.size() - n0 != 1) begin
            errors++;
            $display("FAIL abort_req_count: got %0d want 1", req_log.size() - n0);
        end
        checks++;
        if (done_cnt != d0 || we_cnt != w0) begin
            errors++;
            $display("FAIL abort_no_fill: got done=%0d we=%0d want %0d/%0d", done_cnt, we_cnt, d0, w0);
        end
    endtask

    task automatic test_idle_abort();
        miss_req  = 1'b1;
        miss_addr = 32'h0000_5000;
        abort     = 1'b1;
        #1;
        checks++;
        if (miss_gnt !== 1'b0) begin errors++; $display("FAIL idle_abort_gnt: got %b want 0", miss_gnt); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_abort_busy: got %b want 0", busy); end
        miss_req = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        start_miss(32'h0000_4010, 2'b01);
        wait_done();
        checks++;
        if (c_data !== line_of(32'h4010) || c_index !== 8'h02) begin
            errors++;
            $display("FAIL b2b_first: got data=%h idx=%h want %h/02", c_data, c_index, line_of(32'h4010));
        end
        // Present the next miss during WRITE; it must be taken the following cycle.
        miss_req  = 1'b1;
        miss_addr = 32'h0000_4020;
        miss_way  = 2'b10;
        #1;
        checks++;
        if (miss_gnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt_write: got %b want 0", miss_gnt); end
        @(negedge clk);
        checks++;
        if (miss_gnt !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gnt_next: got gnt=%b busy=%b want 1/0", miss_gnt, busy);
        end
        t0 = cyc;
        @(negedge clk);
        miss_req = 1'b0;
        wait_done();
        checks++;
        if (c_data !== line_of(32'h4020) || c_index !== 8'h04 || c_way !== 2'b10 || lat != 4) begin
            errors++;
            $display("FAIL b2b_second: got data=%h idx=%h way=%b lat=%0d want %h/04/10/4",
                     c_data, c_index, c_way, lat, line_of(32'h4020));
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_stall();
        test_bus_error();
        test_abort();
        test_idle_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
